// File: rtl/arm_dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO page (OUT, CYCLES, STORES, TX FIFO, STATUS).
// Optional misaligned-access trap enabled by defining ARM_DMEM_MISALIGN_TRAP_EN.
module arm_dmem_responder #(
    parameter int          RAM_WORDS  = 64,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        TxValid,
    output logic [31:0] TxData,
    input  logic        TxReady,
    output logic [31:0] LedOut,
    output logic        ErrMisalign
);

    localparam int RAW = $clog2(RAM_WORDS);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    typedef enum logic [2:0] {
        OFF_OUT    = 3'd0,
        OFF_CYCLES = 3'd1,
        OFF_STORES = 3'd2,
        OFF_TXDATA = 3'd3,
        OFF_STATUS = 3'd4
    } mmioOff_e;

    logic [31:0]    ram [RAM_WORDS];
    logic [31:0]    fifoMem [FIFO_DEPTH];
    logic [FAW-1:0] rdPtr, wrPtr;
    logic [FAW:0]   count;
    logic           ovf;
    logic [31:0]    outReg, cycles, stores;
    logic           errFlag;

    logic           ramHit, mmioHit, misAlign, storeOk;
    logic [RAW-1:0] ramIdx;
    mmioOff_e       off;
    logic           full, empty, push, pop, pushAcc, ovfSet, ovfClr;
    logic [31:0]    status;

    assign ramHit  = ALUResult < RAM_BYTES;
    assign mmioHit = ALUResult[31:16] == MMIO_BASE[31:16];
    assign ramIdx  = ALUResult[RAW+1:2];
    assign off     = mmioOff_e'(ALUResult[4:2]);

`ifdef ARM_DMEM_MISALIGN_TRAP_EN
    assign misAlign = ALUResult[1:0] != 2'b00;
`else
    assign misAlign = 1'b0;
`endif

    // Misaligned stores are swallowed entirely when the trap is enabled.
    assign storeOk = MemWrite && !misAlign;

    assign empty   = count == '0;
    assign full    = count == (FAW+1)'(FIFO_DEPTH);
    assign TxValid = !empty;
    assign TxData  = TxValid ? fifoMem[rdPtr] : 32'd0;
    assign pop     = TxValid && TxReady;
    assign push    = storeOk && mmioHit && off == OFF_TXDATA;
    assign pushAcc = push && (!full || pop);
    assign ovfSet  = push && full && !pop;
    assign ovfClr  = storeOk && mmioHit && off == OFF_STATUS && WriteData[2];
    assign status  = {{(27-FAW){1'b0}}, count, 1'b0, ovf, full, empty};

    assign LedOut      = outReg;
    assign ErrMisalign = errFlag;

    always_comb begin
        ReadData = 32'd0;
        if (misAlign && (ramHit || mmioHit)) begin
            ReadData = 32'hDEAD_BEEF;
        end else if (ramHit) begin
            ReadData = ram[ramIdx];
        end else if (mmioHit) begin
            case (off)
                OFF_OUT:    ReadData = outReg;
                OFF_CYCLES: ReadData = cycles;
                OFF_STORES: ReadData = stores;
                OFF_STATUS: ReadData = status;
                default:    ReadData = 32'd0;
            endcase
        end
    end

    // Storage arrays carry no reset; the FIFO head is masked through TxValid instead.
    always_ff @(posedge clk) begin
        if (storeOk && ramHit) begin
            ram[ramIdx] <= WriteData;
        end
        if (pushAcc) begin
            fifoMem[wrPtr] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outReg  <= 32'd0;
            cycles  <= 32'd0;
            stores  <= 32'd0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            errFlag <= 1'b0;
        end else begin
            cycles <= cycles + 32'd1;
            if (storeOk && ramHit) begin
                stores <= stores + 32'd1;
            end
            if (storeOk && mmioHit && off == OFF_OUT) begin
                outReg <= WriteData;
            end
            if (pushAcc) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (pushAcc && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !pushAcc) begin
                count <= count - 1'b1;
            end
            // A clear racing an overflow loses so the overflow is never hidden.
            if (ovfSet) begin
                ovf <= 1'b1;
            end else if (ovfClr) begin
                ovf <= 1'b0;
            end
            if (misAlign && (MemWrite || ramHit || mmioHit)) begin
                errFlag <= 1'b1;
            end
        end
    end

endmodule
